// File: rtl/myproject_div_pkg.sv
// Shared types and constants for the 27s / 8ns -> 19 sequential signed divider.
// Holds the controller state encoding, the quotient saturation bounds and the
// counter-width helper used to size the bit-iteration counter.
package myproject_div_pkg;

   localparam int unsigned DIN0_W = 27;
   localparam int unsigned DIN1_W = 8;
   localparam int unsigned DOUT_W = 19;

   // Saturation bounds of the signed quotient
   localparam int QMAX = int'(2 ** (DOUT_W - 1)) - 1;
   localparam int QMIN = -int'(2 ** (DOUT_W - 1));

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Ceiling log2, minimum 1 bit
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v << 1;
         r = r + 1;
      end
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/myproject_div_step.sv
// One restoring-division step (combinational).
// Ports:
//   i_rem  partial remainder (DIV_W+1 bits, always < divisor)
//   i_bit  next dividend bit shifted in at the LSB
//   i_div  unsigned divisor
//   o_rem  new partial remainder
//   o_q    quotient bit (1 when the trial subtraction did not underflow)
module myproject_div_step #(
   parameter int unsigned DIV_W = 8
) (
   input  logic [DIV_W:0]   i_rem,
   input  logic             i_bit,
   input  logic [DIV_W-1:0] i_div,
   output logic [DIV_W:0]   o_rem,
   output logic             o_q
);

   logic [DIV_W+1:0] w_shift;
   logic [DIV_W+1:0] w_div;
   logic [DIV_W+1:0] w_diff;

   assign w_shift = {i_rem, i_bit};
   assign w_div   = (DIV_W+2)'(i_div);
   assign w_diff  = w_shift - w_div;

   // Keep the difference when non-negative, otherwise restore the shifted value
   assign o_q   = (w_shift >= w_div);
   assign o_rem = o_q ? (DIV_W+1)'(w_diff) : (DIV_W+1)'(w_shift);

endmodule

// File: rtl/myproject_sdiv_27s_8ns_19_seq.sv
// Iterative signed-by-unsigned divider with ap_start/ap_done handshake.
// Divides |din0| by din1 one quotient bit per cycle, then applies the dividend
// sign and saturates the quotient to dout_WIDTH bits.
// Ports:
//   ap_clk, ap_rst      clock, synchronous active-high reset
//   ap_start / ap_ready request / accept (ap_ready = ap_idle & ap_start)
//   ap_idle             high in IDLE only
//   ap_done             one-cycle completion pulse
//   din0, din1          signed dividend, unsigned divisor (captured on accept)
//   dout, rem, ovf      saturated quotient, signed remainder, overflow/div0 flag
module myproject_sdiv_27s_8ns_19_seq
   import myproject_div_pkg::*;
#(
   parameter int unsigned din0_WIDTH = DIN0_W,
   parameter int unsigned din1_WIDTH = DIN1_W,
   parameter int unsigned dout_WIDTH = DOUT_W
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst,
   input  logic                         ap_start,
   output logic                         ap_ready,
   output logic                         ap_idle,
   output logic                         ap_done,
   input  logic signed [din0_WIDTH-1:0] din0,
   input  logic        [din1_WIDTH-1:0] din1,
   output logic signed [dout_WIDTH-1:0] dout,
   output logic signed [din1_WIDTH:0]   rem,
   output logic                         ovf
);

   localparam int unsigned CNT_W = clog2(din0_WIDTH);

   localparam logic [dout_WIDTH-1:0] DOUT_MAX = dout_WIDTH'(QMAX);
   localparam logic [dout_WIDTH-1:0] DOUT_MIN = dout_WIDTH'(QMIN);
   // Largest quotient magnitudes representable for each sign
   localparam logic [din0_WIDTH-1:0] MAG_POS  = din0_WIDTH'(QMAX);
   localparam logic [din0_WIDTH-1:0] MAG_NEG  = din0_WIDTH'(-QMIN);

   state_t                  r_state;
   logic [din0_WIDTH-1:0]   r_dvd;     // dividend magnitude, becomes quotient magnitude
   logic [din1_WIDTH:0]     r_prem;    // partial remainder
   logic [din1_WIDTH-1:0]   r_div;
   logic                    r_neg;
   logic [CNT_W-1:0]        r_cnt;
   logic [dout_WIDTH-1:0]   r_dout;
   logic [din1_WIDTH:0]     r_rem;
   logic                    r_ovf;

   logic [din1_WIDTH:0]     w_prem_nxt;
   logic                    w_qbit;

   myproject_div_step #(
      .DIV_W (din1_WIDTH)
   ) u_step (
      .i_rem (r_prem),
      .i_bit (r_dvd[din0_WIDTH-1]),
      .i_div (r_div),
      .o_rem (w_prem_nxt),
      .o_q   (w_qbit)
   );

   assign ap_idle  = (r_state == IDLE);
   assign ap_ready = ap_idle & ap_start;
   assign ap_done  = (r_state == DONE);
   assign dout     = r_dout;
   assign rem      = r_rem;
   assign ovf      = r_ovf;

   // Controller and datapath
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_state <= IDLE;
         r_dvd   <= '0;
         r_prem  <= '0;
         r_div   <= '0;
         r_neg   <= 1'b0;
         r_cnt   <= '0;
         r_dout  <= '0;
         r_rem   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (ap_start) begin
                  r_neg   <= din0[din0_WIDTH-1];
                  // Unsigned magnitude; the most negative input maps to 2^(W-1)
                  r_dvd   <= din0[din0_WIDTH-1] ? ({din0_WIDTH{1'b0}} - $unsigned(din0))
                                                : $unsigned(din0);
                  r_div   <= din1;
                  r_prem  <= '0;
                  r_cnt   <= CNT_W'(din0_WIDTH - 1);
                  r_state <= CALC;
               end
            end
            CALC: begin
               // Dividend bits leave at the MSB while quotient bits enter at the LSB
               r_prem <= w_prem_nxt;
               r_dvd  <= {r_dvd[din0_WIDTH-2:0], w_qbit};
               r_cnt  <= r_cnt - CNT_W'(1);
               if (r_cnt == '0) r_state <= FIX;
            end
            FIX: begin
               r_state <= DONE;
               if (r_div == '0) begin
                  r_dout <= r_neg ? DOUT_MIN : DOUT_MAX;
                  r_rem  <= '0;
                  r_ovf  <= 1'b1;
               end else begin
                  r_rem <= r_neg ? ({(din1_WIDTH+1){1'b0}} - r_prem) : r_prem;
                  if (!r_neg) begin
                     r_ovf  <= (r_dvd > MAG_POS);
                     r_dout <= (r_dvd > MAG_POS) ? DOUT_MAX : dout_WIDTH'(r_dvd);
                  end else begin
                     r_ovf  <= (r_dvd > MAG_NEG);
                     r_dout <= (r_dvd > MAG_NEG) ? DOUT_MIN
                                                 : dout_WIDTH'({din0_WIDTH{1'b0}} - r_dvd);
                  end
               end
            end
            DONE: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_myproject_sdiv_27s_8ns_19_seq.sv
// Self-checking bench for the sequential signed divider: a cycle-level
// behavioural model (C-style division plus a latency countdown) is compared
// against the DUT on every cycle, with literal expectations on directed cases.
module tb_myproject_sdiv_27s_8ns_19_seq;

   logic               ap_clk;
   logic               ap_rst;
   logic               ap_start;
   logic               ap_ready;
   logic               ap_idle;
   logic               ap_done;
   logic signed [26:0] din0;
   logic        [7:0]  din1;
   logic signed [18:0] dout;
   logic signed [8:0]  rem;
   logic               ovf;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state
   int m_left = 0;
   int e_dout = 0, e_rem = 0, p_q = 0, p_r = 0;
   bit e_ovf = 0, p_o = 0;
   bit chk_en = 0;

   myproject_sdiv_27s_8ns_19_seq dut (
      .ap_clk   (ap_clk),
      .ap_rst   (ap_rst),
      .ap_start (ap_start),
      .ap_ready (ap_ready),
      .ap_idle  (ap_idle),
      .ap_done  (ap_done),
      .din0     (din0),
      .din1     (din1),
      .dout     (dout),
      .rem      (rem),
      .ovf      (ovf)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   task automatic check(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // C semantics: truncate toward zero, remainder takes dividend sign
   function automatic void model(input longint a, input longint b,
                                 output int q, output int r, output bit o);
      longint qq;
      if (b == 0) begin
         q = (a >= 0) ? 262143 : -262144;
         r = 0;
         o = 1'b1;
      end else begin
         qq = a / b;
         r  = int'(a % b);
         o  = 1'b0;
         if (qq > 262143) begin
            q = 262143; o = 1'b1;
         end else if (qq < -262144) begin
            q = -262144; o = 1'b1;
         end else begin
            q = int'(qq);
         end
      end
   endfunction

   // Cycle model: 29 busy cycles after accept, results visible in the done cycle
   always @(posedge ap_clk) begin
      if (ap_rst) begin
         m_left = 0; e_dout = 0; e_rem = 0; e_ovf = 0; chk_en = 1;
      end else if (m_left == 0) begin
         if (ap_start) begin
            model(longint'(din0), longint'(din1), p_q, p_r, p_o);
            m_left = 29;
         end
      end else begin
         m_left = m_left - 1;
         if (m_left == 1) begin
            e_dout = p_q; e_rem = p_r; e_ovf = p_o;
         end
      end
   end

   // Per-cycle compare away from the active edge
   always @(negedge ap_clk) begin
      if (chk_en && !ap_rst) begin
         check("ap_idle",  longint'(ap_idle),  longint'(m_left == 0));
         check("ap_ready", longint'(ap_ready), longint'((m_left == 0) && ap_start));
         check("ap_done",  longint'(ap_done),  longint'(m_left == 1));
         check("dout",     longint'(dout),     longint'(e_dout));
         check("rem",      longint'(rem),      longint'(e_rem));
         check("ovf",      longint'(ovf),      longint'(e_ovf));
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (!ap_idle && n < 60) begin
         @(posedge ap_clk); #1; n++;
      end
      if (!ap_idle) check("idle_timeout", 0, 1);
   endtask

   // Start one operation and wait for ap_done; returns latency and idle-low status
   task automatic start_wait(input logic signed [26:0] a, input logic [7:0] b,
                             output int lat, output bit idle_ok);
      wait_idle();
      @(posedge ap_clk); #1;
      din0 = a; din1 = b; ap_start = 1'b1;
      @(posedge ap_clk); #1;
      ap_start = 1'b0;
      din0 = 27'($urandom); din1 = 8'($urandom);
      lat = 1; idle_ok = 1'b1;
      if (ap_idle) idle_ok = 1'b0;
      while (!ap_done && lat < 40) begin
         @(posedge ap_clk); #1;
         lat++;
         if (ap_idle) idle_ok = 1'b0;
      end
   endtask

   task automatic run_op(input string nm, input logic signed [26:0] a, input logic [7:0] b,
                         input int ed, input int er, input int eo);
      int lat;
      bit iok;
      start_wait(a, b, lat, iok);
      check({nm, ".latency"}, lat, 29);
      check({nm, ".idle_low"}, longint'(iok), 1);
      check({nm, ".dout"}, longint'(dout), ed);
      check({nm, ".rem"}, longint'(rem), er);
      check({nm, ".ovf"}, longint'(ovf), eo);
   endtask

   initial begin
      int acc[$];
      int lat, sel, gap;
      bit iok, saw_done;
      logic signed [26:0] a;
      logic [7:0] b;

      ap_rst = 1'b1; ap_start = 1'b0; din0 = '0; din1 = '0;
      repeat (3) @(posedge ap_clk);
      #1;
      check("reset.idle", longint'(ap_idle), 1);
      check("reset.done", longint'(ap_done), 0);
      check("reset.dout", longint'(dout), 0);
      check("reset.rem",  longint'(rem), 0);
      check("reset.ovf",  longint'(ovf), 0);
      ap_rst = 1'b0;

      run_op("pos",      27'sd1000,      8'd7,   142,     6,  0);
      run_op("neg",     -27'sd1000,      8'd7,  -142,    -6,  0);
      run_op("negexact",-27'sd7,         8'd7,    -1,     0,  0);
      run_op("satpos",   27'sd67108863,  8'd1,  262143,   0,  1);
      run_op("satneg",  -27'sd67108864,  8'd255,-262144, -4,  1);
      run_op("qminok",  -27'sd262144,    8'd1,  -262144,  0,  0);
      run_op("qmaxp1",   27'sd262144,    8'd1,  262143,   0,  1);
      run_op("div0neg", -27'sd5,         8'd0,  -262144,  0,  1);
      run_op("div0zero", 27'sd0,         8'd0,  262143,   0,  1);

      // Reset in the middle of CALC
      wait_idle();
      @(posedge ap_clk); #1;
      din0 = 27'sd1000; din1 = 8'd7; ap_start = 1'b1;
      @(posedge ap_clk); #1;
      ap_start = 1'b0;
      repeat (9) @(posedge ap_clk);
      #1 ap_rst = 1'b1;
      @(posedge ap_clk); #1;
      ap_rst = 1'b0;
      check("midrst.idle", longint'(ap_idle), 1);
      check("midrst.dout", longint'(dout), 0);
      saw_done = 1'b0;
      repeat (40) begin
         @(posedge ap_clk); #1;
         if (ap_done) saw_done = 1'b1;
      end
      check("midrst.no_done", longint'(saw_done), 0);
      run_op("after_rst", 27'sd255, 8'd255, 1, 0, 0);

      // ap_start held high with operands changing every cycle
      wait_idle();
      for (int i = 0; i < 90; i++) begin
         @(posedge ap_clk); #1;
         ap_start = 1'b1;
         din0 = 27'($urandom); din1 = 8'($urandom);
         #1;
         if (ap_ready) acc.push_back(i);
      end
      #1 ap_start = 1'b0;
      check("held.n_accepts", acc.size(), 3);
      for (int k = 0; k < acc.size() && k < 3; k++)
         check("held.accept_cycle", acc[k], 30 * k);

      // Randomized operations checked by the cycle model
      for (int t = 0; t < 40; t++) begin
         sel = int'($urandom_range(0, 3));
         case (sel)
            0: a = 27'($urandom);
            1: a = 27'($signed(int'($urandom_range(0, 4000)) - 2000));
            2: a = 27'($signed(-67108864 + int'($urandom_range(0, 3))));
            default: a = 27'($signed(67108863 - int'($urandom_range(0, 3))));
         endcase
         b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         start_wait(a, b, lat, iok);
         check("rand.latency", lat, 29);
         gap = int'($urandom_range(0, 3));
         repeat (gap) @(posedge ap_clk);
      end
      wait_idle();
      repeat (2) @(posedge ap_clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/myproject_sdiv_27s_8ns_19_seq.md
Name: myproject_sdiv_27s_8ns_19_seq

Overview:
- Iterative signed-by-unsigned divider. It is the inverse companion of the 19s x 8ns -> 27 multiplier in the layernorm datapath.
- Takes a 27-bit signed dividend (scaled product) and an 8-bit unsigned divisor (normalisation factor). Returns a saturated 19-bit signed quotient and a signed remainder.
- Restoring division, one quotient bit per cycle, behind an ap_start/ap_done block-level handshake.

Parameters:
- din0_WIDTH, 27, dividend width (signed).
- din1_WIDTH, 8, divisor width (unsigned).
- dout_WIDTH, 19, quotient width (signed, saturating).

Ports:
- ap_clk  in  1  clock; all state changes on rising edge.
- ap_rst  in  1  synchronous active-high reset.
- ap_start  in  1  request; sampled only in IDLE.
- ap_ready  out  1  combinational; equals ap_idle & ap_start (operands captured this edge).
- ap_idle  out  1  high only in state IDLE.
- ap_done  out  1  one-cycle pulse; dout/rem/ovf valid in this cycle and held until next accept.
- din0  in  din0_WIDTH  signed dividend; sampled on accept edge only.
- din1  in  din1_WIDTH  unsigned divisor; sampled on accept edge only.
- dout  out  dout_WIDTH  signed quotient.
- rem  out  din1_WIDTH+1  signed remainder.
- ovf  out  1  saturation or divide-by-zero flag.

Behaviour:
- Reset: state=IDLE, ap_done=0, dout=0, rem=0, ovf=0, internal counter/accumulators=0.
- Reset applies on any cycle, including mid-CALC. The operation is discarded and no ap_done is issued.
- States and transitions:
  - IDLE -> CALC on ap_start. On that edge: latch sign(din0), |din0| into a 27-bit unsigned register, din1, and cnt=din0_WIDTH-1.
  - CALC: shift the partial remainder left, bring in the next dividend MSB, trial-subtract the divisor. If the result is non-negative, keep it and set the quotient bit; otherwise restore. Decrement cnt. When cnt==0, go to FIX.
  - FIX: apply sign and saturation, register dout/rem/ovf, go to DONE.
  - DONE: ap_done=1 for exactly one cycle, then go to IDLE.
- Latency: accept edge at cycle 0; CALC occupies cycles 1..27; FIX at cycle 28; ap_done high in cycle 29.
- A new accept is possible at the earliest in cycle 30. ap_start held high therefore gives one result per 30 cycles.
- Arithmetic:
  - Truncation toward zero (C semantics).
  - Quotient sign = sign(din0). Remainder sign = sign(din0), with |rem| < din1.
  - |din0| for -2^26 is 2^26 and must be representable in the 27-bit unsigned magnitude.
- Saturation:
  - Signed quotient > 2^18-1 -> dout=262143, ovf=1.
  - Signed quotient < -2^18 -> dout=-262144, ovf=1.
  - Quotient exactly -262144 is in range -> ovf=0.
  - rem stays exact in all saturation cases.
- Divide by zero (din1==0): still takes the full latency. dout=262143 if din0>=0, else -262144. rem=0, ovf=1.
- ap_start asserted outside IDLE is ignored; no queuing.
- Changes on din0/din1 after the accept edge have no effect.

Decomposition:
- Shared package myproject_div_pkg holds:
  - the state enum (IDLE, CALC, FIX, DONE);
  - QMAX/QMIN constants derived from dout_WIDTH;
  - the counter width function clog2(din0_WIDTH).
- One sub-module, myproject_div_step: combinational single restoring step. Inputs: partial remainder (din1_WIDTH+1 bits), next dividend bit, divisor. Outputs: new remainder and quotient bit.
- The top module holds the FSM, registers, sign handling and saturation.

Test Plan:
- din0=1000, din1=7, pulse ap_start -> ap_done exactly 29 cycles after accept; dout=142, rem=6, ovf=0; ap_idle low during cycles 1..29.
- din0=-1000, din1=7 -> dout=-142, rem=-6, ovf=0. Also din0=-7, din1=7 -> dout=-1, rem=0.
- din0=67108863, din1=1 -> dout=262143, ovf=1, rem=0. Also din0=-67108864, din1=255 -> dout=-263172 saturates to -262144, ovf=1, rem=-4.
- din0=-5, din1=0 -> dout=-262144, rem=0, ovf=1. din0=0, din1=0 -> dout=262143, ovf=1.
- Assert ap_rst at cycle 10 of a CALC -> next cycle ap_idle=1, dout=0, no ap_done pulse. A subsequent din0=255, din1=255 -> dout=1, rem=0.
- ap_start held high with operands changing every cycle -> accepts only at cycles 0, 30, 60. Each result matches the operands present on its accept edge. ap_ready high only on those accept cycles.
